// File: rtl/riscv_core_div_seq.sv
// Iterative restoring radix-2 divider for RV32 M-extension DIV/DIVU/REM/REMU.
// All negations and trial subtractions are routed through an external shared adder.
module riscv_core_div_seq #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_valid,
    output logic            o_div_ready,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_srcA,
    input  logic [XLEN-1:0] i_div_srcB,
    input  logic            i_div_flush,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_res_data,
    output logic [XLEN-1:0] o_add_srcA,
    output logic [XLEN-1:0] o_add_srcB,
    input  logic [XLEN-1:0] i_add_result
);

    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NEGA = 3'd1;
    localparam logic [2:0] S_NEGB = 3'd2;
    localparam logic [2:0] S_ITER = 3'd3;
    localparam logic [2:0] S_FIXQ = 3'd4;
    localparam logic [2:0] S_FIXR = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [2:0]      state_r, state_s;
    logic            rem_sel_r, rem_sel_s;
    logic            sgn_r, sgn_s;
    logic [XLEN-1:0] a_r, a_s;
    logic [XLEN-1:0] b_r, b_s;
    logic [XLEN-1:0] abs_d_r, abs_d_s;
    logic [XLEN-1:0] neg_d_r, neg_d_s;
    logic [XLEN-1:0] rem_r, rem_s;
    logic [XLEN-1:0] quo_r, quo_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            res_valid_r, res_valid_s;
    logic [XLEN-1:0] res_data_r, res_data_s;
    logic            div_ready_r;

    logic [XLEN-1:0] sh_s;
    logic            take_s;
    logic [XLEN-1:0] rem_fix_s;

    // Shifted partial remainder; its lost top bit forces a subtract.
    assign sh_s      = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
    assign take_s    = rem_r[XLEN-1] || (sh_s >= abs_d_r);
    assign rem_fix_s = (sgn_r && a_r[XLEN-1]) ? i_add_result : rem_r;

    // Shared adder operand selection per sequencer state.
    always_comb begin
        o_add_srcA = ZERO;
        o_add_srcB = ZERO;
        case (state_r)
            S_NEGA: begin o_add_srcA = ~a_r;   o_add_srcB = ONE;     end
            S_NEGB: begin o_add_srcA = ~b_r;   o_add_srcB = ONE;     end
            S_ITER: begin o_add_srcA = sh_s;   o_add_srcB = neg_d_r; end
            S_FIXQ: begin o_add_srcA = ~quo_r; o_add_srcB = ONE;     end
            S_FIXR: begin o_add_srcA = ~rem_r; o_add_srcB = ONE;     end
            default: begin o_add_srcA = ZERO;  o_add_srcB = ZERO;    end
        endcase
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_s     = state_r;
        rem_sel_s   = rem_sel_r;
        sgn_s       = sgn_r;
        a_s         = a_r;
        b_s         = b_r;
        abs_d_s     = abs_d_r;
        neg_d_s     = neg_d_r;
        rem_s       = rem_r;
        quo_s       = quo_r;
        cnt_s       = cnt_r;
        res_valid_s = res_valid_r;
        res_data_s  = res_data_r;
        if (i_div_flush) begin
            state_s     = S_IDLE;
            res_valid_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (i_div_valid) begin
                        rem_sel_s = i_div_op[1];
                        sgn_s     = ~i_div_op[0];
                        a_s       = i_div_srcA;
                        b_s       = i_div_srcB;
                        if (i_div_srcB == ZERO) begin
                            res_data_s  = i_div_op[1] ? i_div_srcA : ALL_ONES;
                            res_valid_s = 1'b1;
                            state_s     = S_DONE;
                        end else if (!i_div_op[0] && (i_div_srcA == MIN_NEG) && (i_div_srcB == ALL_ONES)) begin
                            res_data_s  = i_div_op[1] ? ZERO : MIN_NEG;
                            res_valid_s = 1'b1;
                            state_s     = S_DONE;
                        end else begin
                            state_s = S_NEGA;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_NEGA: begin
                    // |A| goes straight into the quotient register.
                    quo_s   = (sgn_r && a_r[XLEN-1]) ? i_add_result : a_r;
                    state_s = S_NEGB;
                end
                S_NEGB: begin
                    if (sgn_r && b_r[XLEN-1]) begin
                        abs_d_s = i_add_result;
                        neg_d_s = b_r;
                    end else begin
                        abs_d_s = b_r;
                        neg_d_s = i_add_result;
                    end
                    rem_s   = ZERO;
                    cnt_s   = {CW{1'b0}};
                    state_s = S_ITER;
                end
                S_ITER: begin
                    rem_s = take_s ? i_add_result : sh_s;
                    quo_s = {quo_r[XLEN-2:0], take_s};
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_s = S_FIXQ;
                    end else begin
                        state_s = S_ITER;
                    end
                end
                S_FIXQ: begin
                    if (sgn_r && (a_r[XLEN-1] ^ b_r[XLEN-1])) begin
                        quo_s = i_add_result;
                    end else begin
                        quo_s = quo_r;
                    end
                    state_s = S_FIXR;
                end
                S_FIXR: begin
                    rem_s       = rem_fix_s;
                    res_data_s  = rem_sel_r ? rem_fix_s : quo_r;
                    res_valid_s = 1'b1;
                    state_s     = S_DONE;
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        res_valid_s = 1'b0;
                        state_s     = S_IDLE;
                    end else begin
                        state_s = S_DONE;
                    end
                end
                default: begin
                    res_valid_s = 1'b0;
                    state_s     = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= S_IDLE;
            rem_sel_r   <= 1'b0;
            sgn_r       <= 1'b0;
            a_r         <= ZERO;
            b_r         <= ZERO;
            abs_d_r     <= ZERO;
            neg_d_r     <= ZERO;
            rem_r       <= ZERO;
            quo_r       <= ZERO;
            cnt_r       <= {CW{1'b0}};
            res_valid_r <= 1'b0;
            res_data_r  <= ZERO;
            div_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            rem_sel_r   <= rem_sel_s;
            sgn_r       <= sgn_s;
            a_r         <= a_s;
            b_r         <= b_s;
            abs_d_r     <= abs_d_s;
            neg_d_r     <= neg_d_s;
            rem_r       <= rem_s;
            quo_r       <= quo_s;
            cnt_r       <= cnt_s;
            res_valid_r <= res_valid_s;
            res_data_r  <= res_data_s;
            div_ready_r <= (state_s == S_IDLE);
        end
    end

    assign o_div_ready = div_ready_r;
    assign o_res_valid = res_valid_r;
    assign o_res_data  = res_data_r;

endmodule

// File: tb/tb_riscv_core_div_seq.sv
// Self-checking bench for riscv_core_div_seq: directed, corner, flush, reset,
// backpressure and randomized cases against an arithmetic reference model.
module tb_riscv_core_div_seq;

    logic        clk;
    logic        rst_n;
    logic        div_valid;
    logic        div_ready;
    logic [1:0]  div_op;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_flush;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;

    int checks = 0;
    int errors = 0;

    localparam int LAT_NORMAL  = 37;
    localparam int LAT_SPECIAL = 1;

    riscv_core_div_seq #(.XLEN(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_div_valid  (div_valid),
        .o_div_ready  (div_ready),
        .i_div_op     (div_op),
        .i_div_srcA   (div_a),
        .i_div_srcB   (div_b),
        .i_div_flush  (div_flush),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_data   (res_data),
        .o_add_srcA   (add_a),
        .o_add_srcB   (add_b),
        .i_add_result (add_sum)
    );

    // External shared adder.
    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder ports must be idle whenever the divider is in IDLE or DONE.
    always @(negedge clk) begin
        if (rst_n && (div_ready || res_valid)) begin
            checks++;
            if (add_a !== 32'h0 || add_b !== 32'h0) begin
                errors++;
                $display("FAIL adder_idle: srcA=%h srcB=%h required 0/0", add_a, add_b);
            end
        end
    end

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return LAT_SPECIAL;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_NORMAL;
    endfunction

    // Issues one request and waits (bounded) for the result; returns edges from accept to valid.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] data);
        int w;
        w = 0;
        @(negedge clk);
        while (!div_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        div_valid = 1'b1;
        div_op    = op;
        div_a     = a;
        div_b     = b;
        @(posedge clk);
        lat = 1;
        #1 div_valid = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk);
            lat++;
        end
        data = res_data;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b data=%h required 1/0/0", div_ready, res_valid, res_data);
        end
        checks++;
        if (add_a !== 32'h0 || add_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_adder: srcA=%h srcB=%h required 0/0", add_a, add_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [8]  = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11};
        logic [31:0] as  [8]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [8]  = '{32'h0000_000E, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
        int lat;
        logic [31:0] data;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], lat, data);
            checks++;
            if (data !== exp[i]) begin
                errors++;
                $display("FAIL directed_data[%0d]: got %h required %h", i, data, exp[i]);
            end
            checks++;
            if (lat != LAT_NORMAL) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, LAT_NORMAL);
            end
            consume();
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b10};
        logic [31:0] as  [5] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0};
        int lat;
        logic [31:0] data;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], as[i], bs[i], lat, data);
            checks++;
            if (data !== exp[i]) begin
                errors++;
                $display("FAIL special_data[%0d]: got %h required %h", i, data, exp[i]);
            end
            checks++;
            if (lat != LAT_SPECIAL) begin
                errors++;
                $display("FAIL special_latency[%0d]: got %0d required %0d", i, lat, LAT_SPECIAL);
            end
            consume();
        end
    endtask

    task automatic check_recovery(input string tag);
        int lat;
        logic [31:0] data;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s_no_result: res_valid rose=1 required 0", tag);
        end
        do_op(2'b01, 32'hFFFF_FFFF, 32'h1, lat, data);
        checks++;
        if (data !== 32'hFFFF_FFFF || lat != LAT_NORMAL) begin
            errors++;
            $display("FAIL %s_after: data=%h lat=%0d required ffffffff/%0d", tag, data, lat, LAT_NORMAL);
        end
        consume();
    endtask

    task automatic test_flush();
        @(negedge clk);
        div_valid = 1'b1; div_op = 2'b01; div_a = 32'hFFFF_FFFF; div_b = 32'd3;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        div_flush = 1'b1;
        @(posedge clk);
        #1 div_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: ready=%b valid=%b required 1/0", div_ready, res_valid);
        end
        check_recovery("flush");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        div_valid = 1'b1; div_op = 2'b00; div_a = 32'h7654_3210; div_b = 32'd9;
        @(posedge clk);
        #1 div_valid = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 32'h0 || add_a !== 32'h0 || add_b !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b data=%h srcA=%h srcB=%h required 1/0/0/0/0",
                     div_ready, res_valid, res_data, add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_recovery("reset");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] data;
        logic [31:0] exp;
        exp = ref_div(2'b00, 32'd1000, 32'hFFFF_FFFD);
        do_op(2'b00, 32'd1000, 32'hFFFF_FFFD, lat, data);
        checks++;
        if (data !== exp) begin
            errors++;
            $display("FAIL bp_data: got %h required %h", data, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp || div_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b required 1/%h/0", i, res_valid, res_data, div_ready, exp);
            end
        end
        consume();
        @(negedge clk);
        checks++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b required 1/0", div_ready, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] data;
        do_op(2'b11, 32'd12345, 32'd100, lat, data);
        res_ready = 1'b1;
        div_valid = 1'b1; div_op = 2'b01; div_a = 32'd50; div_b = 32'd5;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (div_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_accept: ready=%b valid=%b required 1/0", div_ready, res_valid);
        end
        div_valid = 1'b0;
        do_op(2'b01, 32'd50, 32'd5, lat, data);
        checks++;
        if (data !== 32'd10 || lat != LAT_NORMAL) begin
            errors++;
            $display("FAIL b2b_second: data=%h lat=%0d required 0000000a/%0d", data, lat, LAT_NORMAL);
        end
        consume();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] data;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
                3: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(op, a, b, lat, data);
            checks++;
            if (data !== ref_div(op, a, b) || lat != ref_lat(op, a, b)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: data=%h lat=%0d required %h/%0d",
                         i, op, a, b, data, lat, ref_div(op, a, b), ref_lat(op, a, b));
            end
            consume();
        end
    endtask

    initial begin
        div_valid = 1'b0;
        div_op    = 2'b00;
        div_a     = 32'h0;
        div_b     = 32'h0;
        div_flush = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_directed();
        test_special();
        test_flush();
        test_async_reset();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_core_div_seq.md
# riscv_core_div_seq

Iterative divide sequencer for the RV32IMC M-extension (DIV/DIVU/REM/REMU) in the EX stage. Restoring radix-2 division runs over a fixed number of cycles. All two's-complement negations and trial subtractions go through one external shared XLEN-bit adder, which this block drives through its adder ports. Operands arrive on a valid/ready handshake from the pipeline; results leave on a valid/ready handshake back to it.

## Interface
- XLEN, 32, datapath width; iteration count equals XLEN.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_div_valid  in  1  request valid.
- o_div_ready  out  1  high only in IDLE.
- i_div_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_div_srcA  in  XLEN  dividend.
- i_div_srcB  in  XLEN  divisor.
- i_div_flush  in  1  synchronous abort from hazard/branch unit.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  consumer accepts the result.
- o_res_data  out  XLEN  quotient for DIV/DIVU, remainder for REM/REMU.
- o_add_srcA  out  XLEN  shared adder operand A.
- o_add_srcB  out  XLEN  shared adder operand B.
- i_add_result  in  XLEN  shared adder sum; combinational, valid in the same cycle.

## Operation
- States: IDLE, NEGA, NEGB, ITER, FIXQ, FIXR, DONE.
- IDLE: accept when i_div_valid && !i_div_flush. On accept, latch op, A and B, and compute sgn = signed op.
  - If B == 0: result is all-ones (DIV/DIVU) or A (REM/REMU); go to DONE.
  - Else if sgn && A == 0x8000_0000 && B == all-ones: result is 0x8000_0000 (DIV) or 0 (REM); go to DONE.
  - Else go to NEGA.
- NEGA: adder = ~A + 1. If sgn && A[XLEN-1], then absA ← sum; else absA ← A.
- NEGB: adder = ~B + 1.
  - If sgn && B[XLEN-1]: absD ← sum, negD ← B.
  - Else: absD ← B, negD ← sum.
  - Clear rem, set quo ← absA, clear counter.
- ITER, once per cycle for XLEN cycles:
  - {msb, sh} = {rem, quo[XLEN-1]}; the XLEN+1-bit shifted partial remainder.
  - Adder = sh + negD.
  - take = msb || (sh >= absD), an internal unsigned comparator. The adder carry is not used.
  - rem ← take ? sum : sh.
  - quo ← {quo[XLEN-2:0], take}.
  - After cycle XLEN, go to FIXQ.
- FIXQ: adder = ~quo + 1. If sgn && (A[XLEN-1] ^ B[XLEN-1]), then quo ← sum.
- FIXR: adder = ~rem + 1. If sgn && A[XLEN-1], then rem ← sum. Select o_res_data by op, then go to DONE.
- DONE: o_res_valid = 1. Stay until i_res_ready, then go to IDLE.
- Adder operands are 0 in IDLE and DONE.
- FIXQ and FIXR always consume their cycle, whether or not a negation applies, so latency is fixed.
- i_div_flush in any state: go to IDLE on the next edge, drop o_res_valid, discard the result. Flush outranks a same-cycle i_res_ready or i_div_valid.
- Results are modulo 2^XLEN and match the RISC-V spec, including the zero-divide and overflow cases.

## Timing
- Reset (async assert, sync release): state IDLE, o_div_ready 1, o_res_valid 0, o_res_data 0, o_add_srcA/B 0, internal registers 0.
- Accept edge = cycle 0.
  - Normal path: NEGA in cycle 1, NEGB in cycle 2, ITER in cycles 3–34, FIXQ in cycle 35, FIXR in cycle 36, o_res_valid high from cycle 37. Latency is XLEN+5.
  - Special cases (zero divisor, overflow): o_res_valid high in cycle 1.
- o_res_data and o_res_valid are registered and held stable while o_res_valid && !i_res_ready.
- Result handshake completes on an edge with o_res_valid && i_res_ready. o_div_ready rises in the next cycle.
- No back-to-back accept in the same cycle a result leaves. Throughput is one op per XLEN+6 cycles minimum.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.

## Test plan
- DIVU 100/7 -> 0x0000000E exactly 37 cycles after accept. REMU 100/7 -> 0x00000002.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF. DIV 7/−2 -> 0xFFFFFFFD; REM 7/−2 -> 0x00000001.
- Divide by zero, A = 0x12345678: DIVU and DIV -> 0xFFFFFFFF, REM -> 0x12345678; valid one cycle after accept.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, one cycle. DIVU on the same operands -> 0 after 37 cycles.
- Flush at ITER cycle 10: o_res_valid never rises and o_div_ready is 1 the next cycle. Then DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF. Async reset mid-ITER gives the same result.
- Backpressure: hold i_res_ready low for 5 cycles after valid. Data must not change and o_div_ready must stay 0. Releasing it completes the handshake; ready is 1 the next cycle. Adder-port monitor checks srcA/srcB are 0 in IDLE and DONE.
